// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill,
        StWrite,
        StDone
    } state_e;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    function automatic int unsigned IDX_W(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned TAG_W(input int unsigned addr_w, input int unsigned lines);
        return addr_w - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_lane_fmt.sv
// Byte-lane formatter: store enables/alignment, load extraction/extension, misalign detect.
module dcache_lane_fmt
    import dcache_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        sext,
    input  logic [31:0] store_data,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [2:0]  sz;
    logic [31:0] shifted;

    always_comb begin
        // Unknown size codes behave as word accesses.
        sz        = (size == SZ_BYTE || size == SZ_HALF) ? size : SZ_WORD;
        shifted   = word >> {off, 3'b000};
        wdata     = store_data << {off, 3'b000};
        be        = 4'hF;
        load_data = shifted;
        misalign  = 1'b0;
        unique case (sz)
            SZ_BYTE: begin
                be        = 4'b0001 << off;
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << off;
                load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
                misalign  = off[0];
            end
            default: begin
                be        = 4'hF;
                load_data = shifted;
                misalign  = |off;
            end
        endcase
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with an MMIO register window.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int unsigned LINES     = 64,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] MMIO_BASE = 32'h2000,
    parameter int unsigned MMIO_CH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           write_data,
    input  logic                  memwrite,
    input  logic                  memread,
    input  logic [3:0]            sign_mask,
    input  logic                  flush,
    output logic [31:0]           read_data,
    output logic                  clk_stall,
    output logic                  misalign,
    output logic [32*MMIO_CH-1:0] mmio_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-3:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned IW   = IDX_W(LINES);
    localparam int unsigned TW   = TAG_W(ADDR_W, LINES);
    localparam int unsigned CH_W = (MMIO_CH > 1) ? $clog2(MMIO_CH) : 1;
    localparam logic [ADDR_W-1:0] MMIO_LO = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] MMIO_HI = ADDR_W'(MMIO_BASE + 32'(4 * MMIO_CH));

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic              store_q;
    logic              flush_pend_q;
    logic [LINES-1:0]  valid_q;

    logic [TW-1:0] tag_mem  [LINES];
    logic [31:0]   data_mem [LINES];
    logic [31:0]   mmio_q   [MMIO_CH];

    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic [CH_W-1:0] ch;
    logic            hit;
    logic            mmio_hit;
    logic            req_in;
    logic [31:0]     fmt_word;
    logic [3:0]      fmt_be;
    logic [31:0]     fmt_wdata;
    logic [31:0]     fmt_load;
    logic            fmt_mis;
    logic [31:0]     byte_mask;
    logic [31:0]     line_merged;
    logic [31:0]     mmio_merged;
    logic            line_store;
    logic            mmio_store;

    always_comb begin
        idx         = addr_q[IW+1:2];
        tag         = addr_q[ADDR_W-1:IW+2];
        ch          = CH_W'((addr_q - MMIO_LO) >> 2);
        hit         = valid_q[idx] && (tag_mem[idx] == tag);
        mmio_hit    = (addr_q >= MMIO_LO) && (addr_q < MMIO_HI);
        req_in      = memread | memwrite;
        // Fill data only matters in FILL; otherwise the lookup source is MMIO or the line.
        fmt_word    = (state_q == StFill) ? mem_rdata : (mmio_hit ? mmio_q[ch] : data_mem[idx]);
        byte_mask   = {{8{fmt_be[3]}}, {8{fmt_be[2]}}, {8{fmt_be[1]}}, {8{fmt_be[0]}}};
        line_merged = (data_mem[idx] & ~byte_mask) | (fmt_wdata & byte_mask);
        mmio_merged = (mmio_q[ch] & ~byte_mask) | (fmt_wdata & byte_mask);
        line_store  = (state_q == StLookup) && store_q && !fmt_mis && !mmio_hit && hit;
        mmio_store  = (state_q == StLookup) && store_q && !fmt_mis && mmio_hit;
    end

    dcache_lane_fmt u_fmt (
        .off        (addr_q[1:0]),
        .size       (mask_q[2:0]),
        .sext       (mask_q[3]),
        .store_data (wdata_q),
        .word       (fmt_word),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .load_data  (fmt_load),
        .misalign   (fmt_mis)
    );

    always_ff @(posedge clk) begin
        if (line_store) begin
            data_mem[idx] <= line_merged;
        end
        if (state_q == StFill && mem_ack) begin
            data_mem[idx] <= mem_rdata;
            tag_mem[idx]  <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MMIO_CH); k++) begin
                mmio_q[k] <= '0;
            end
        end else if (mmio_store) begin
            mmio_q[ch] <= mmio_merged;
        end
    end

    for (genvar k = 0; k < int'(MMIO_CH); k++) begin : g_mmio_out
        assign mmio_out[32*k +: 32] = mmio_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            store_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            read_data    <= '0;
            clk_stall    <= 1'b0;
            misalign     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
        end else begin
            if (flush && state_q != StIdle) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (flush_pend_q || (flush && !req_in)) begin
                        valid_q <= '0;
                    end
                    // A flush that arrives alongside a request waits for the next idle cycle.
                    flush_pend_q <= flush && req_in;
                    if (req_in) begin
                        addr_q    <= addr;
                        wdata_q   <= write_data;
                        mask_q    <= sign_mask;
                        store_q   <= memwrite;
                        clk_stall <= 1'b1;
                        state_q   <= StLookup;
                    end
                end
                StLookup: begin
                    if (fmt_mis) begin
                        misalign  <= 1'b1;
                        read_data <= '0;
                        state_q   <= StDone;
                    end else if (mmio_hit) begin
                        if (!store_q) begin
                            read_data <= fmt_load;
                        end
                        state_q <= StDone;
                    end else if (!store_q) begin
                        if (hit) begin
                            read_data <= fmt_load;
                            state_q   <= StDone;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_be   <= 4'hF;
                            mem_addr <= addr_q[ADDR_W-1:2];
                            state_q  <= StFill;
                        end
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_be    <= fmt_be;
                        mem_wdata <= fmt_wdata;
                        mem_addr  <= addr_q[ADDR_W-1:2];
                        state_q   <= StWrite;
                    end
                end
                StFill: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        read_data    <= fmt_load;
                        state_q      <= StDone;
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    clk_stall <= 1'b0;
                    misalign  <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised, direct-mapped, write-through, no-write-allocate data cache for the RV32I core's load/store port.
- Sits between the core and the backing data memory, which is reached through a req/ack handshake.
- Decodes a window of MMIO_CH 32-bit output registers that generalises the single LED register.
- Stalls the core through clk_stall; adds misalignment detection and a cache invalidate.

Parameters:
- LINES, 64, number of one-word cache lines; power of 2, at least 2; IDX_W = log2(LINES).
- ADDR_W, 32, CPU address width; tag width TAG_W = ADDR_W-2-IDX_W.
- MMIO_BASE, 32'h2000, byte address of MMIO channel 0; channel k is at MMIO_BASE+4k.
- MMIO_CH, 4, number of 32-bit MMIO output registers (1..16).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  byte address of the access
- write_data  in  32  store data, right-aligned
- memwrite  in  1  store request
- memread  in  1  load request
- sign_mask  in  4  [2:0] size: 001 byte, 011 half, 111 word; [3] sign-extend loads
- flush  in  1  invalidate-all request pulse
- read_data  out  32  formatted load result, registered
- clk_stall  out  1  core must hold while high, registered
- misalign  out  1  one-cycle pulse on a rejected misaligned access
- mmio_out  out  32*MMIO_CH  MMIO registers; channel k in bits [32k+31:32k]
- mem_req, mem_we  out  1  backing-memory request and write strobe
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-aligned store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  fill data
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset state: state IDLE, all valid bits 0, clk_stall 0, read_data 0, misalign 0, mmio_out 0, mem_req 0, mem_we 0, mem_be 0. Tag/data RAM contents are don't-care.
- Reset mid-operation: mem_req drops asynchronously and the outstanding transaction is abandoned. The backing memory must tolerate a dropped request.
- Address split: off = addr[1:0], idx = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2].
- MMIO hit: addr in [MMIO_BASE, MMIO_BASE+4*MMIO_CH). MMIO accesses never touch the cache or backing memory.
- Access alignment: a half access is misaligned when off[0]=1; a word access is misaligned when off≠0.
- Store alignment: byte access, be = 1<<off; half access, be = 3<<off; word access, be = 4'hF. wdata = write_data shifted left by 8*off.
- Load format: word >> 8*off, truncated to size, then sign- or zero-extended per sign_mask[3].
- Size code outside {001, 011, 111}: treated as word.
- FSM states: IDLE, LOOKUP, FILL, WRITE, DONE.
- IDLE:
  - On memread|memwrite: latch addr, write_data, sign_mask and op into buffers; clk_stall<=1; go to LOOKUP.
  - memread and memwrite both high: the access is a store.
  - flush while idle with no request: clear all valid bits this cycle.
  - flush arriving together with a request, or while busy: held pending and applied on the next cycle spent in IDLE.
- LOOKUP:
  - Misaligned access: misalign<=1, read_data<=0, no store performed; go to DONE.
  - MMIO access: loads format the channel register; stores merge into the register under be. Go to DONE.
  - Load hit (valid & tag match): read_data<=formatted line; go to DONE.
  - Load miss: mem_req<=1, mem_we<=0, mem_be<=F; go to FILL.
  - Store: if it hits, merge bytes into the line under be. Always issue mem_req<=1, mem_we<=1; go to WRITE. A store miss does not allocate.
- FILL: wait for mem_ack. On ack: drop mem_req, write the line (tag, data, valid=1), read_data<=formatted mem_rdata; go to DONE.
- WRITE: wait for mem_ack. On ack: drop mem_req; go to DONE.
- Request hold: mem_addr, mem_wdata, mem_be and mem_we stay stable while mem_req is high.
- DONE: clk_stall<=0, misalign<=0; go to IDLE.
- The core holds its request inputs stable while clk_stall is high. A request still present in IDLE after DONE is a new access.
- Latency, counted in cycles with clk_stall high:
  - Hit, MMIO or misaligned access: 2.
  - Miss or store: 3 + (cycles from mem_req to mem_ack).

Decomposition:
- Package dcache_pkg holds:
  - FSM state encoding.
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - Field-width localparam helpers IDX_W and TAG_W.
- Sub-module dcache_lane_fmt: purely combinational. Computes be and aligned wdata for stores, the extended load result, and the misalign flag. Reused for cache hits, fills and MMIO.
- Tag/data/valid arrays stay inside dcache_dm.

Test Plan:
- Reset, then lb from 0x1004 (miss) with mem_rdata=32'h8070_60F0, ack after 2 cycles -> exactly one mem_req; read_data=32'hFFFF_FFF0; clk_stall high 5 cycles. Repeat lbu at 0x1005 -> hit, no mem_req, read_data=32'h0000_0060, stall 2 cycles.
- sh 16'hBEEF at 0x1006 after that line is filled -> mem_be=4'b1100, mem_wdata=32'hBEEF_0000. A following lw at 0x1004 hits with read_data=32'hBEEF_60F0.
- sw 32'h0000_00A5 to 0x2000, then sb 8'h3C to 0x2005 with MMIO_CH=4 -> mmio_out[7:0]=8'hA5; mmio_out[47:40]=8'h3C; no mem_req.
- lw at 0x1002 and lh at 0x1003 -> each gives a one-cycle misalign pulse, read_data=0, no mem_req, stall 2 cycles.
- With LINES=4, fill line 0x1000 and then load 0x1010 (same index, new tag) -> the second access misses and refills. flush, then load 0x1010 again -> miss.
- Drive rst_n low while in FILL with mem_ack withheld -> mem_req falls immediately; after release state is IDLE, clk_stall=0, and the next access to the same address misses.
